// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and sizing for the I$/D$ backing-memory arbiter.
// Imported by the arbiter top and its round-robin grant block.
package mem_arbiter_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int LINE_BITS = 512;
  localparam int DEF_READ_BEATS = LINE_BITS / MEM_DATA_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BUSY = 2'd1,
    WR_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-input round-robin grant: a tie goes to the requester
// that did not win the previous accepted command.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output req_id_t    winner
);

  req_id_t last_grant;

  always_comb begin
    winner = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
    if (req == 2'b01) winner = REQ_IC;
    else if (req == 2'b10) winner = REQ_DC;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant <= REQ_IC;
    else if (update) last_grant <= winner;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I$ and D$; holds the grant
// for a whole write beat or a READ_BEATS-beat line refill.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = MEM_DATA_BITS,
  parameter int MASK_BITS  = DATA_BITS / 8,
  parameter int READ_BEATS = DEF_READ_BEATS
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 ic_req_valid,
  output logic                 ic_req_ready,
  input  logic [ADDR_BITS-1:0] ic_req_addr,
  input  logic                 ic_req_rw,
  input  logic                 ic_req_data_valid,
  output logic                 ic_req_data_ready,
  input  logic [DATA_BITS-1:0] ic_req_data_bits,
  input  logic [MASK_BITS-1:0] ic_req_data_mask,
  output logic                 ic_resp_valid,
  output logic [DATA_BITS-1:0] ic_resp_data,

  input  logic                 dc_req_valid,
  output logic                 dc_req_ready,
  input  logic [ADDR_BITS-1:0] dc_req_addr,
  input  logic                 dc_req_rw,
  input  logic                 dc_req_data_valid,
  output logic                 dc_req_data_ready,
  input  logic [DATA_BITS-1:0] dc_req_data_bits,
  input  logic [MASK_BITS-1:0] dc_req_data_mask,
  output logic                 dc_resp_valid,
  output logic [DATA_BITS-1:0] dc_resp_data,

  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic                 mem_req_rw,
  output logic                 mem_req_data_valid,
  input  logic                 mem_req_data_ready,
  output logic [DATA_BITS-1:0] mem_req_data_bits,
  output logic [MASK_BITS-1:0] mem_req_data_mask,
  input  logic                 mem_resp_valid,
  input  logic [DATA_BITS-1:0] mem_resp_data,

  output logic                 resp_orphan
);

  localparam int CNT_W = ceil_log2(READ_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BEATS - 1);

  arb_state_t       state;
  req_id_t          owner;
  req_id_t          winner;
  req_id_t          sel;
  logic [CNT_W-1:0] beat_cnt;
  logic             orphan_q;
  logic             cmd_hs;
  logic             data_hs;
  logic             sel_rw;
  logic             sel_dv;
  logic             sel_dc;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({dc_req_valid, ic_req_valid}),
    .update (cmd_hs),
    .winner (winner)
  );

  always_comb begin
    sel    = (state == IDLE) ? winner : owner;
    sel_dc = (sel == REQ_DC);
    sel_rw = sel_dc ? dc_req_rw : ic_req_rw;
    sel_dv = sel_dc ? dc_req_data_valid : ic_req_data_valid;
  end

  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;
  assign resp_orphan  = orphan_q;

  assign cmd_hs  = mem_req_valid & mem_req_ready;
  assign data_hs = mem_req_data_valid & mem_req_data_ready;

  // Handshake outputs are forced low while reset is held.
  always_comb begin
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    ic_req_ready       = 1'b0;
    dc_req_ready       = 1'b0;
    ic_req_data_ready  = 1'b0;
    dc_req_data_ready  = 1'b0;
    ic_resp_valid      = 1'b0;
    dc_resp_valid      = 1'b0;
    mem_req_addr       = sel_dc ? dc_req_addr : ic_req_addr;
    mem_req_rw         = sel_rw;
    mem_req_data_bits  = sel_dc ? dc_req_data_bits : ic_req_data_bits;
    mem_req_data_mask  = sel_dc ? dc_req_data_mask : ic_req_data_mask;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          mem_req_valid      = ic_req_valid | dc_req_valid;
          mem_req_data_valid = sel_dv & sel_rw & mem_req_valid;
          ic_req_ready       = !sel_dc & mem_req_valid & mem_req_ready;
          dc_req_ready       = sel_dc & mem_req_valid & mem_req_ready;
          ic_req_data_ready  = !sel_dc & mem_req_valid
                               & mem_req_data_ready & sel_rw;
          dc_req_data_ready  = sel_dc & mem_req_valid
                               & mem_req_data_ready & sel_rw;
        end
        RD_BUSY: begin
          ic_resp_valid = !sel_dc & mem_resp_valid;
          dc_resp_valid = sel_dc & mem_resp_valid;
        end
        WR_DATA: begin
          mem_req_data_valid = sel_dv;
          ic_req_data_ready  = !sel_dc & mem_req_data_ready;
          dc_req_data_ready  = sel_dc & mem_req_data_ready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= REQ_IC;
      beat_cnt <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (mem_resp_valid && state != RD_BUSY) orphan_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cmd_hs) begin
            owner    <= winner;
            beat_cnt <= '0;
            if (!sel_rw) state <= RD_BUSY;
            else if (!data_hs) state <= WR_DATA;
          end
        end
        RD_BUSY: begin
          if (mem_resp_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (data_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: IDLE vector table, directed sequences,
// then random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = 16;
  localparam int RB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_req_rw;
  logic [AB-1:0] ic_req_addr;
  logic          ic_req_data_valid, ic_req_data_ready;
  logic [DB-1:0] ic_req_data_bits;
  logic [MB-1:0] ic_req_data_mask;
  logic          ic_resp_valid;
  logic [DB-1:0] ic_resp_data;
  logic          dc_req_valid, dc_req_ready, dc_req_rw;
  logic [AB-1:0] dc_req_addr;
  logic          dc_req_data_valid, dc_req_data_ready;
  logic [DB-1:0] dc_req_data_bits;
  logic [MB-1:0] dc_req_data_mask;
  logic          dc_resp_valid;
  logic [DB-1:0] dc_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DB-1:0] mem_req_data_bits;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic [DB-1:0] mem_resp_data;
  logic          resp_orphan;

  mem_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .MASK_BITS(MB), .READ_BEATS(RB)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_req_rw(ic_req_rw),
    .ic_req_data_valid(ic_req_data_valid),
    .ic_req_data_ready(ic_req_data_ready),
    .ic_req_data_bits(ic_req_data_bits),
    .ic_req_data_mask(ic_req_data_mask),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
    .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .resp_orphan(resp_orphan)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_rw = 0; ic_req_addr = '0;
    ic_req_data_valid = 0; ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
    dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    step();
    step();
    reset = 0;
  endtask

  // IDLE-only combinational vectors; last grant is IC, so a tie goes to DC.
  typedef struct {
    logic icv, icrw, icdv, dcv, dcrw, dcdv, mrdy, mdrdy;
    logic e_mv, e_icr, e_dcr, e_rw, e_dv, e_icdr, e_dcdr, e_seldc;
  } vec_t;

  vec_t vt[10];

  // Random-phase requester, memory and reference-model state.
  logic [1:0]    rq_busy, rq_rw, rq_cmd, rq_dat;
  logic [AB-1:0] rq_addr[2];
  logic [DB-1:0] rq_data[2];
  logic [MB-1:0] rq_mask[2];
  logic [DB-1:0] resp_q[$];
  int            m_left;
  bit            m_wr;
  int            m_last;
  int            m_owner;

  initial begin
    reset = 1;
    clear_inputs();

    vt[0] = '{0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1};
    vt[1] = '{1,0,0,0,0,0,1,1, 1,1,0,0,0,0,0,0};
    vt[2] = '{0,0,0,1,0,0,1,1, 1,0,1,0,0,0,0,1};
    vt[3] = '{1,0,0,1,0,0,1,1, 1,0,1,0,0,0,0,1};
    vt[4] = '{1,0,0,1,0,0,0,0, 1,0,0,0,0,0,0,1};
    vt[5] = '{1,1,1,0,0,0,1,1, 1,1,0,1,1,1,0,0};
    vt[6] = '{1,0,0,1,1,1,1,1, 1,0,1,1,1,0,1,1};
    vt[7] = '{1,0,1,0,0,0,1,1, 1,1,0,0,0,0,0,0};
    vt[8] = '{1,1,1,1,1,0,1,1, 1,0,1,1,0,0,1,1};
    vt[9] = '{1,1,1,0,0,0,0,0, 1,0,0,1,1,0,0,0};

    do_reset();
    #1;
    chk("rst_outs", {mem_req_valid, mem_req_data_valid, ic_req_ready,
        dc_req_ready, ic_req_data_ready, dc_req_data_ready,
        ic_resp_valid, dc_resp_valid, resp_orphan}, 0);

    for (int i = 0; i < 10; i++) begin
      step();
      ic_req_addr = 28'h1111111; dc_req_addr = 28'h2222222;
      ic_req_data_bits = 128'h11; dc_req_data_bits = 128'h22;
      ic_req_data_mask = 16'h000F; dc_req_data_mask = 16'hF000;
      ic_req_valid = vt[i].icv; ic_req_rw = vt[i].icrw;
      ic_req_data_valid = vt[i].icdv;
      dc_req_valid = vt[i].dcv; dc_req_rw = vt[i].dcrw;
      dc_req_data_valid = vt[i].dcdv;
      mem_req_ready = vt[i].mrdy; mem_req_data_ready = vt[i].mdrdy;
      #1;
      chk($sformatf("v%0d_mv", i), mem_req_valid, vt[i].e_mv);
      chk($sformatf("v%0d_icr", i), ic_req_ready, vt[i].e_icr);
      chk($sformatf("v%0d_dcr", i), dc_req_ready, vt[i].e_dcr);
      chk($sformatf("v%0d_rw", i), mem_req_rw, vt[i].e_rw);
      chk($sformatf("v%0d_dv", i), mem_req_data_valid, vt[i].e_dv);
      chk($sformatf("v%0d_icdr", i), ic_req_data_ready, vt[i].e_icdr);
      chk($sformatf("v%0d_dcdr", i), dc_req_data_ready, vt[i].e_dcdr);
      chk($sformatf("v%0d_addr", i), mem_req_addr,
          vt[i].e_seldc ? 28'h2222222 : 28'h1111111);
      chk($sformatf("v%0d_mask", i), mem_req_data_mask,
          vt[i].e_seldc ? 16'hF000 : 16'h000F);
      clear_inputs();
    end

    // DC read alone, one gap cycle between beats
    do_reset();
    dc_req_valid = 1; dc_req_addr = 28'h0000010; mem_req_ready = 1;
    #1;
    chk("a_grant", dc_req_ready, 1);
    chk("a_addr", mem_req_addr, 28'h10);
    step();
    dc_req_valid = 0; mem_req_ready = 0;
    for (int k = 0; k < 5; k++) begin
      mem_resp_valid = (k != 1);
      mem_resp_data = 128'hA0 + 128'((k == 0) ? 0 : k - 1);
      #1;
      chk($sformatf("a_dcv%0d", k), dc_resp_valid, k != 1);
      chk($sformatf("a_icv%0d", k), ic_resp_valid, 0);
      if (k != 1)
        chk($sformatf("a_dat%0d", k), dc_resp_data,
            128'hA0 + 128'((k == 0) ? 0 : k - 1));
      step();
    end
    mem_resp_valid = 0; dc_req_valid = 1;
    #1;
    chk("a_idle", mem_req_valid, 1);
    chk("a_orphan", resp_orphan, 0);
    dc_req_valid = 0;

    // simultaneous reads after reset
    do_reset();
    ic_req_valid = 1; dc_req_valid = 1; mem_req_ready = 1;
    #1;
    chk("b_dc_first", dc_req_ready, 1);
    chk("b_ic_wait", ic_req_ready, 0);
    step();
    dc_req_valid = 0;
    for (int k = 0; k < RB; k++) begin
      mem_resp_valid = 1; mem_resp_data = 128'hB0 + 128'(k);
      #1;
      chk($sformatf("b_dcv%0d", k), dc_resp_valid, 1);
      chk($sformatf("b_icv%0d", k), ic_resp_valid, 0);
      chk($sformatf("b_icr%0d", k), ic_req_ready, 0);
      step();
    end
    mem_resp_valid = 0;
    #1;
    chk("b_ic_next", ic_req_ready, 1);
    step();
    ic_req_valid = 0; mem_req_ready = 0;
    for (int k = 0; k < RB; k++) begin
      mem_resp_valid = 1;
      #1;
      chk($sformatf("b2_icv%0d", k), ic_resp_valid, 1);
      chk($sformatf("b2_dcv%0d", k), dc_resp_valid, 0);
      step();
    end
    mem_resp_valid = 0;

    // back-to-back contention with single-cycle writes
    do_reset();
    ic_req_valid = 1; dc_req_valid = 1; ic_req_rw = 1; dc_req_rw = 1;
    ic_req_data_valid = 1; dc_req_data_valid = 1;
    mem_req_ready = 1; mem_req_data_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("c_dc%0d", k), dc_req_ready, (k % 2) == 0);
      chk($sformatf("c_ic%0d", k), ic_req_ready, (k % 2) == 1);
      step();
    end
    clear_inputs();

    // DC write with data ready held off three cycles
    do_reset();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h5;
    dc_req_data_bits = 128'h00000000_00000000_DEADBEEF_00000000;
    dc_req_data_mask = 16'h00F0; dc_req_data_valid = 1;
    mem_req_ready = 1;
    #1;
    chk("d_grant", dc_req_ready, 1);
    chk("d_rw", mem_req_rw, 1);
    chk("d_dv", mem_req_data_valid, 1);
    chk("d_dr0", dc_req_data_ready, 0);
    step();
    dc_req_valid = 0; ic_req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("d_mv%0d", k), mem_req_valid, 0);
      chk($sformatf("d_icr%0d", k), ic_req_ready, 0);
      chk($sformatf("d_bits%0d", k), mem_req_data_bits,
          128'h00000000_00000000_DEADBEEF_00000000);
      chk($sformatf("d_mask%0d", k), mem_req_data_mask, 16'h00F0);
      chk($sformatf("d_held%0d", k), mem_req_data_valid, 1);
      step();
    end
    mem_req_data_ready = 1;
    #1;
    chk("d_data_hs", dc_req_data_ready, 1);
    chk("d_icr_hs", ic_req_ready, 0);
    chk("d_noresp", {ic_resp_valid, dc_resp_valid}, 0);
    step();
    dc_req_data_valid = 0; mem_req_data_ready = 0;
    #1;
    chk("d_ic_after", ic_req_ready, 1);
    ic_req_valid = 0; mem_req_ready = 0;

    // response with nothing outstanding
    do_reset();
    step();
    mem_resp_valid = 1; mem_resp_data = 128'hBAD;
    #1;
    chk("e_icv", ic_resp_valid, 0);
    chk("e_dcv", dc_resp_valid, 0);
    step();
    mem_resp_valid = 0;
    #1;
    chk("e_orphan", resp_orphan, 1);
    repeat (3) step();
    chk("e_sticky", resp_orphan, 1);
    reset = 1;
    step();
    chk("e_cleared", resp_orphan, 0);
    reset = 0;

    // reset in the middle of an IC refill
    do_reset();
    ic_req_valid = 1; ic_req_addr = 28'h77; mem_req_ready = 1;
    #1;
    chk("f_grant", ic_req_ready, 1);
    step();
    ic_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1;
    step();
    step();
    reset = 1; ic_req_valid = 1; dc_req_valid = 1;
    mem_req_ready = 1; mem_req_data_ready = 1;
    step();
    chk("f_rst_outs", {mem_req_valid, mem_req_data_valid, ic_req_ready,
        dc_req_ready, ic_req_data_ready, dc_req_data_ready,
        ic_resp_valid, dc_resp_valid, resp_orphan}, 0);
    reset = 0;
    clear_inputs();
    dc_req_valid = 1; mem_req_ready = 1;
    #1;
    chk("f_dc_grant", dc_req_ready, 1);
    step();
    dc_req_valid = 0; mem_req_ready = 0;
    for (int k = 0; k < RB; k++) begin
      mem_resp_valid = 1;
      #1;
      chk($sformatf("f_dcv%0d", k), dc_resp_valid, 1);
      chk($sformatf("f_icv%0d", k), ic_resp_valid, 0);
      step();
    end
    mem_resp_valid = 0; dc_req_valid = 1;
    #1;
    chk("f_idle", mem_req_valid, 1);
    chk("f_orphan", resp_orphan, 0);

    // random traffic against the transaction-level model
    do_reset();
    rq_busy = '0; rq_rw = '0; rq_cmd = '0; rq_dat = '0;
    resp_q.delete();
    m_left = 0; m_wr = 0; m_last = 0; m_owner = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit drain, resp, cmd_hs, data_hs, m_idle;
      int g, own, expg;
      logic [1:0] v, acc;
      if (cyc != 0) step();
      drain = (cyc >= 3700);
      for (int i = 0; i < 2; i++) begin
        if (!rq_busy[i] && !drain && $urandom_range(0, 3) == 0) begin
          rq_busy[i] = 1; rq_cmd[i] = 0; rq_dat[i] = 0;
          rq_rw[i] = ($urandom_range(0, 2) == 0);
          rq_addr[i] = AB'($urandom());
          rq_data[i] = rnd128();
          rq_mask[i] = MB'($urandom());
        end else if (rq_busy[i] && !rq_cmd[i] && !rq_rw[i]
                     && $urandom_range(0, 15) == 0) begin
          rq_busy[i] = 0;
        end
      end
      ic_req_valid = rq_busy[0] && !rq_cmd[0];
      ic_req_rw = rq_rw[0]; ic_req_addr = rq_addr[0];
      ic_req_data_bits = rq_data[0]; ic_req_data_mask = rq_mask[0];
      ic_req_data_valid = rq_busy[0] && rq_rw[0] && !rq_dat[0]
                          && ($urandom_range(0, 3) != 0);
      dc_req_valid = rq_busy[1] && !rq_cmd[1];
      dc_req_rw = rq_rw[1]; dc_req_addr = rq_addr[1];
      dc_req_data_bits = rq_data[1]; dc_req_data_mask = rq_mask[1];
      dc_req_data_valid = rq_busy[1] && rq_rw[1] && !rq_dat[1]
                          && ($urandom_range(0, 3) != 0);
      mem_req_ready = $urandom_range(0, 1);
      mem_req_data_ready = ($urandom_range(0, 1) == 1)
                           && (mem_req_ready || m_wr);
      mem_resp_valid = (resp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_resp_data = (resp_q.size() > 0) ? resp_q[0] : rnd128();
      #4;
      m_idle = (m_left == 0) && !m_wr;
      v = {dc_req_valid, ic_req_valid};
      cmd_hs = mem_req_valid && mem_req_ready;
      data_hs = mem_req_data_valid && mem_req_data_ready;
      resp = mem_resp_valid;
      acc = {dc_req_data_valid && dc_req_data_ready,
             ic_req_data_valid && ic_req_data_ready};
      g = dc_req_ready ? 1 : 0;
      if (!m_idle)
        chk("r_busy", {mem_req_valid, ic_req_ready, dc_req_ready}, 0);
      else
        chk("r_mv", mem_req_valid, v != 2'b00);
      if (m_idle && cmd_hs) begin
        expg = (v == 2'b11) ? 1 - m_last : (v[1] ? 1 : 0);
        chk("r_grant", g, expg);
        chk("r_one", {ic_req_ready, dc_req_ready}, (g == 1) ? 2'b01 : 2'b10);
        chk("r_addr", mem_req_addr, rq_addr[g]);
        chk("r_rw", mem_req_rw, rq_rw[g]);
      end
      own = m_idle ? g : m_owner;
      if (data_hs) begin
        chk("r_wbits", mem_req_data_bits, rq_data[own]);
        chk("r_wmask", mem_req_data_mask, rq_mask[own]);
      end
      chk("r_dacc", acc,
          data_hs ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00);
      chk("r_icresp", ic_resp_valid, resp && m_left > 0 && m_owner == 0);
      chk("r_dcresp", dc_resp_valid, resp && m_left > 0 && m_owner == 1);
      if (resp) begin
        void'(resp_q.pop_front());
        if (m_left > 0) m_left--;
      end
      if (m_idle && cmd_hs) begin
        m_last = g; m_owner = g;
        if (!rq_rw[g]) begin
          m_left = RB;
          for (int k = 0; k < RB; k++) resp_q.push_back(rnd128());
        end else if (!data_hs) begin
          m_wr = 1;
        end
      end else if (m_wr && data_hs) begin
        m_wr = 0;
      end
      if (ic_req_valid && ic_req_ready) rq_cmd[0] = 1;
      if (dc_req_valid && dc_req_ready) rq_cmd[1] = 1;
      if (acc[0]) rq_dat[0] = 1;
      if (acc[1]) rq_dat[1] = 1;
      for (int i = 0; i < 2; i++)
        if (rq_busy[i] && rq_cmd[i] && (!rq_rw[i] || rq_dat[i]))
          rq_busy[i] = 0;
    end
    chk("r_drain", {32'(resp_q.size()), 32'(m_left), 31'd0, m_wr}, 0);
    chk("r_no_orphan", resp_orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
